// File: rtl/cfu_simd_mac_multi.sv
// cfu_simd_mac_multi
// SIMD multiply-accumulate custom function unit for the CPU CFU port.
// It computes packed signed lane dot products into NUM_ACC selectable
// accumulators. Each lane gets separate input and filter offsets. It also
// provides sticky overflow status and the plain ADD/SUB/MUL ops.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_payload_function_id  [2:0] op, [9:3] funct7 (MAC: [5:3] subop, [8:6] acc index)
//   cmd_payload_inputs_0/1   operands (A / filter lanes, B / input lanes)
//   rsp_valid / rsp_ready    response handshake
//   rsp_payload_outputs_0    result
//   dbg_state                current FSM state (IDLE=0, BUSY=1, RESP=2)
//
// Handshake: a command is accepted on a rising edge where cmd_valid &&
// cmd_ready. A response is consumed on a rising edge where rsp_valid &&
// rsp_ready. While rsp_valid is high, the response payload stays stable.
// cmd_ready is high only in IDLE, so there is never more than one command
// in flight.
module cfu_simd_mac_multi #(
  parameter int ELEM_W      = 8,
  parameter int DATA_W      = 32,
  parameter int NUM_ACC     = 4,
  parameter int MAC_LATENCY = 2,
  parameter int SATURATE    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_payload_function_id,
  input  logic [DATA_W-1:0] cmd_payload_inputs_0,
  input  logic [DATA_W-1:0] cmd_payload_inputs_1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_payload_outputs_0,
  output logic [1:0]        dbg_state
);

  localparam int LANES = DATA_W / ELEM_W;
  localparam int IDX_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int CNT_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [DATA_W-1:0] ACC_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] ACC_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [9:0]         fid_q;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [DATA_W-1:0]  acc [NUM_ACC];
  logic [DATA_W-1:0]  in_off, flt_off;
  logic [NUM_ACC-1:0] ovf;
  logic [DATA_W-1:0]  rsp_data;

  logic               accept, do_single, do_accum;
  logic [9:0]         fid_s;
  logic [DATA_W-1:0]  a_s, b_s;
  logic [2:0]         op, subop, idx_full;
  logic [IDX_W-1:0]   idx;
  logic               is_accum;
  logic [DATA_W-1:0]  acc_cur, dot, sum_raw, acc_new, single_res;
  logic               ovf_hit;
  logic               unused_bits;

  assign cmd_ready             = (state == IDLE);
  assign rsp_valid             = (state == RESP);
  assign rsp_payload_outputs_0 = rsp_data;
  assign dbg_state             = state;
  assign accept                = cmd_valid && cmd_ready;

  // In IDLE the live command is decoded, so single-cycle ops and
  // MAC_LATENCY=1 accumulates need no capture delay. During BUSY the
  // operands captured at acceptance are used.
  assign fid_s    = (state == IDLE) ? cmd_payload_function_id : fid_q;
  assign a_s      = (state == IDLE) ? cmd_payload_inputs_0 : a_q;
  assign b_s      = (state == IDLE) ? cmd_payload_inputs_1 : b_q;
  assign op       = fid_s[2:0];
  assign subop    = fid_s[5:3];
  assign idx_full = fid_s[8:6];
  assign idx      = (NUM_ACC == 1) ? '0 : idx_full[IDX_W-1:0];
  assign is_accum = (op == 3'd3) && (subop == 3'd0);
  assign acc_cur  = acc[idx];
  assign unused_bits = ^{fid_s[9], idx_full};

  // Lane dot product. The signed size cast sign-extends each lane.
  // The DATA_W-bit sum wraps, so only the low DATA_W product bits matter.
  always_comb begin
    dot = '0;
    for (int l = 0; l < LANES; l++) begin
      logic signed [ELEM_W-1:0] la, lb;
      la  = a_s[l*ELEM_W +: ELEM_W];
      lb  = b_s[l*ELEM_W +: ELEM_W];
      dot = dot + (DATA_W'(la) + flt_off) * (DATA_W'(lb) + in_off);
    end
  end

  assign sum_raw = acc_cur + dot;
  assign ovf_hit = (acc_cur[DATA_W-1] == dot[DATA_W-1]) &&
                   (sum_raw[DATA_W-1] != acc_cur[DATA_W-1]);
  assign acc_new = (SATURATE != 0 && ovf_hit) ?
                   (acc_cur[DATA_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;

  always_comb begin
    single_res = '0;
    case (op)
      3'd0: single_res = a_s + b_s;
      3'd1: single_res = a_s - b_s;
      3'd2: single_res = a_s * b_s;
      3'd3: begin
        case (subop)
          3'd4, 3'd5: single_res = acc_cur;
          3'd6:       single_res = a_s;
          default:    single_res = '0;
        endcase
      end
      3'd4:    single_res = DATA_W'(ovf);
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    do_single = 1'b0;
    do_accum  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!is_accum) begin
            do_single = 1'b1;
            state_n   = RESP;
          end else if (MAC_LATENCY == 1) begin
            do_accum = 1'b1;
            state_n  = RESP;
          end else begin
            cnt_n   = CNT_W'(MAC_LATENCY - 1);
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        // The counter reaches zero on this edge.
        if (cnt == CNT_W'(1)) begin
          do_accum = 1'b1;
          state_n  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fid_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      in_off   <= '0;
      flt_off  <= '0;
      ovf      <= '0;
      rsp_data <= '0;
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
    end else begin
      if (accept) begin
        fid_q <= cmd_payload_function_id;
        a_q   <= cmd_payload_inputs_0;
        b_q   <= cmd_payload_inputs_1;
      end
      if (do_single) begin
        rsp_data <= single_res;
        if (op == 3'd3) begin
          case (subop)
            3'd1, 3'd5: acc[idx] <= '0;
            3'd2:       in_off   <= a_s;
            3'd3:       flt_off  <= a_s;
            3'd6:       acc[idx] <= a_s;
            default: ;
          endcase
        end else if (op == 3'd4) begin
          ovf <= '0;
        end
      end
      if (do_accum) begin
        acc[idx] <= acc_new;
        rsp_data <= acc_new;
        if (ovf_hit) ovf[idx] <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cfu_simd_mac_multi.md
Name: cfu_simd_mac_multi

Overview:
Parametrised successor to the single-accumulator SIMD MAC custom function unit on the CPU's CFU command/response port. Computes packed signed lane dot-products with separate input and filter offsets, into NUM_ACC selectable accumulators. Supports optional saturation, a configurable multi-cycle MAC latency and sticky overflow status. Keeps the plain ADD/SUB/MUL ops for software compatibility.

Parameters:
ELEM_W, 8, signed lane width; DATA_W/ELEM_W lanes per operand word
DATA_W, 32, operand/result width; must be a multiple of ELEM_W
NUM_ACC, 4, number of accumulators; power of two, 1..8
MAC_LATENCY, 2, cycles from acceptance to rsp_valid for ACCUM ops; >=1
SATURATE, 0, 0 = wrap-around accumulate; 1 = clamp to signed DATA_W range

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command
cmd_payload_function_id  in  10  [2:0] op, [9:3] funct7
cmd_payload_inputs_0  in  DATA_W  operand A / filter lanes
cmd_payload_inputs_1  in  DATA_W  operand B / input lanes
rsp_valid  out  1  response available
rsp_ready  in  1  CPU accepts response
rsp_payload_outputs_0  out  DATA_W  result

Behaviour:
- Reset (async, active-high) clears: rsp_valid=0, rsp_payload_outputs_0=0, all accumulators, input_offset, filter_offset and overflow flags. cmd_ready=1 after reset.
- Any in-flight command is discarded on reset; no response is produced for it.
- FSM states: IDLE, BUSY, RESP.
  - cmd_ready = (state==IDLE).
  - Acceptance = cmd_valid & cmd_ready. Operands and function_id are captured at acceptance; later input changes are ignored.
  - IDLE -> RESP on acceptance of any single-cycle op: rsp_valid=1 the next cycle.
  - IDLE -> BUSY on acceptance of ACCUM. A down-counter loads MAC_LATENCY-1; BUSY -> RESP when it reaches 0, so rsp_valid rises exactly MAC_LATENCY cycles after acceptance. MAC_LATENCY=1 goes directly to RESP.
  - RESP holds rsp_valid and payload stable until rsp_ready=1, then -> IDLE.
  - No back-to-back acceptance in the cycle rsp_ready is seen; next accept is possible one cycle later.
- Ops on function_id[2:0]:
  - 0 ADD, 1 SUB, 2 MUL: result = low DATA_W bits of the operation.
  - 3 MAC family: funct7[2:0] = subop, funct7[5:3] = acc index. Index bits above log2(NUM_ACC) are ignored.
  - 4 STATUS: result = zero-extended sticky overflow bits (bit i = acc i); reading clears all overflow flags.
  - 5..7: result = 0, no state change.
- MAC subops:
  - 0 ACCUM: acc += sum over lanes of (sext(A_lane)+filter_offset)*(sext(B_lane)+input_offset). Result = new acc value. Lane products and sum are DATA_W-bit signed.
  - 1 CLEAR: acc = 0; result 0.
  - 2 SET_IN_OFFSET: input_offset = inputs_0; result 0.
  - 3 SET_FLT_OFFSET: filter_offset = inputs_0; result 0.
  - 4 READ: result = acc; acc unchanged.
  - 5 READ_CLEAR: result = old acc; acc = 0.
  - 6 SET_ACC: acc = inputs_0; result = inputs_0.
  - 7: result 0, no state change.
- Overflow during ACCUM (signed overflow of acc + sum) sets that accumulator's overflow flag in both modes.
  - SATURATE=0: acc wraps.
  - SATURATE=1: acc clamps to 0x7FFFFFFF / 0x80000000 (DATA_W-scaled).
- Only the addressed accumulator changes; other accumulators are untouched.

Test Plan:
- Reset mid-BUSY (MAC_LATENCY=3, assert reset 1 cycle after ACCUM accept) -> rsp_valid=0 with no later response; READ acc0 -> 0; cmd_ready=1.
- SET_IN_OFFSET 128, SET_FLT_OFFSET 0; ACCUM acc1 A=0x01020304, B=0x80808080 (lanes -128) -> products 0 -> result 0. Then ACCUM acc1 B=0x01010101 -> 129*10=1290. Acc0 READ -> 0.
- ACCUM timing, MAC_LATENCY=2 -> rsp_valid exactly 2 cycles after accept. rsp_ready held low 5 cycles -> payload stable, cmd_ready=0 throughout. rsp_ready=1 -> cmd_ready=1 one cycle later.
- SET_ACC acc2=0x7FFFFFF0, ACCUM lanes summing to +0x20 -> SATURATE=1: 0x7FFFFFFF; SATURATE=0: 0x80000010. STATUS -> 0x4 in both modes; second STATUS -> 0.
- READ_CLEAR acc3 after SET_ACC 0x1234 -> returns 0x1234; subsequent READ -> 0.
- ADD 5+7 -> 12; SUB 3-5 -> 0xFFFFFFFE; MUL 0x10000*0x10000 -> 0; op 6 -> 0 with no accumulator change.
